// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: on a halt edge, snapshots PC, ACC and a cycle
// counter, then streams them as a framed word sequence to a UART.
module debug_frame_tx #(
    parameter int CANT_BITS_OPCODE   = 5,
    parameter int PC_LENGTH          = 11,
    parameter int ACC_LENGTH         = 16,
    parameter int CNT_LENGTH         = 32,
    parameter int OUTPUT_WORD_LENGTH = 8,
    parameter logic [CANT_BITS_OPCODE-1:0]   HALT_OPCODE = '0,
    parameter logic [OUTPUT_WORD_LENGTH-1:0] HEADER_WORD = 8'hA5
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [CANT_BITS_OPCODE-1:0]   i_opcode,
    input  logic [PC_LENGTH-1:0]          i_PC,
    input  logic [ACC_LENGTH-1:0]         i_ACC,
    input  logic                          i_tx_done,
    output logic                          o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx,
    output logic                          o_busy,
    output logic                          o_frame_done
);

    localparam int W      = OUTPUT_WORD_LENGTH;
    localparam int PC_W   = (PC_LENGTH + W - 1) / W;
    localparam int ACC_W  = (ACC_LENGTH + W - 1) / W;
    localparam int CNT_W  = (CNT_LENGTH + W - 1) / W;
    localparam int N      = 1 + PC_W + ACC_W + CNT_W;
    localparam int K_BITS = $clog2(N);

    localparam logic [K_BITS-1:0]     K_LAST  = K_BITS'(N - 1);
    localparam logic [K_BITS-1:0]     K_ONE   = K_BITS'(1);
    localparam logic [CNT_LENGTH-1:0] CNT_ONE = CNT_LENGTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [K_BITS-1:0]     k, k_n;
    logic [CNT_LENGTH-1:0] cnt;
    logic [PC_LENGTH-1:0]  snap_pc;
    logic [ACC_LENGTH-1:0] snap_acc;
    logic [CNT_LENGTH-1:0] snap_cnt;
    logic                  halt_q;
    logic                  done_q;
    logic [W-1:0]          data_q;

    logic is_halt;
    logic trigger;
    logic done_edge;

    logic [PC_W*W-1:0]     pc_pad;
    logic [ACC_W*W-1:0]    acc_pad;
    logic [CNT_W*W-1:0]    cnt_pad;
    logic [N-1:0][W-1:0]   frame;
    logic [W-1:0]          word_k;

    assign is_halt   = (i_opcode == HALT_OPCODE);
    assign trigger   = is_halt & ~halt_q;
    assign done_edge = i_tx_done & ~done_q;

    // Free-running cycle counter that sticks at all-ones
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt    <= '0;
            halt_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (cnt != '1)
                cnt <= cnt + CNT_ONE;
            halt_q <= is_halt;
            done_q <= i_tx_done;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            snap_pc  <= '0;
            snap_acc <= '0;
            snap_cnt <= '0;
        end else if (state == IDLE && trigger) begin
            snap_pc  <= i_PC;
            snap_acc <= i_ACC;
            snap_cnt <= cnt;
        end
    end

    // Fields are zero-padded to whole words, LS word first
    always_comb begin
        pc_pad  = '0;
        acc_pad = '0;
        cnt_pad = '0;
        pc_pad[PC_LENGTH-1:0]   = snap_pc;
        acc_pad[ACC_LENGTH-1:0] = snap_acc;
        cnt_pad[CNT_LENGTH-1:0] = snap_cnt;
        frame = '0;
        frame[0] = HEADER_WORD;
        frame[PC_W:1] = pc_pad;
        frame[PC_W+ACC_W:PC_W+1] = acc_pad;
        frame[N-1:PC_W+ACC_W+1] = cnt_pad;
    end

    assign word_k = frame[k];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            k      <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            if (state == START)
                data_q <= word_k;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = START;
                    k_n     = '0;
                end
            end
            START: state_n = WAIT;
            WAIT: begin
                if (done_edge) begin
                    if (k == K_LAST) begin
                        state_n = DONE;
                    end else begin
                        k_n     = k + K_ONE;
                        state_n = START;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: begin
                state_n = IDLE;
                k_n     = '0;
            end
        endcase
    end

    always_comb begin
        o_tx_start   = (state == START);
        o_data_tx    = (state == START) ? word_k : data_q;
        o_busy       = (state != IDLE);
        o_frame_done = (state == DONE);
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: default build plus a 4-bit
// counter build sharing the same stimulus.
module tb_debug_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opcode;
    logic [10:0] pc;
    logic [15:0] acc;
    logic        auto_ack;
    logic        man_done;
    logic        ack_done = 1'b0;
    logic        tx_done;

    logic        tx_start, busy, fdone;
    logic [7:0]  data;
    logic        tx_start2, busy2, fdone2;
    logic [7:0]  data2;

    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] cyc;
    logic [31:0] exp_cnt;
    logic [7:0]  q[$];
    logic [7:0]  q2[$];
    logic [7:0]  ew[9];

    always #5 clk = ~clk;

    assign tx_done = auto_ack ? ack_done : man_done;

    debug_frame_tx dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_opcode    (opcode),
        .i_PC        (pc),
        .i_ACC       (acc),
        .i_tx_done   (tx_done),
        .o_tx_start  (tx_start),
        .o_data_tx   (data),
        .o_busy      (busy),
        .o_frame_done(fdone)
    );

    debug_frame_tx #(.CNT_LENGTH(4)) dut2 (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_opcode    (opcode),
        .i_PC        (pc),
        .i_ACC       (acc),
        .i_tx_done   (tx_done),
        .o_tx_start  (tx_start2),
        .o_data_tx   (data2),
        .o_busy      (busy2),
        .o_frame_done(fdone2)
    );

    // Reference cycle count since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    always @(negedge clk) begin
        if (tx_start)  q.push_back(data);
        if (tx_start2) q2.push_back(data2);
        if (fdone)     fd_cnt++;
    end

    // UART stand-in: one-cycle done pulse a few cycles after each start
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt  = 0;
            ack_done = 1'b0;
        end else begin
            ack_done = 1'b0;
            if (tx_start) begin
                ack_cnt = 4;
            end else if (ack_cnt != 0) begin
                ack_cnt--;
                if (ack_cnt == 0) ack_done = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mk(input logic [10:0] p, input logic [15:0] a,
                      input logic [31:0] c);
        ew = '{8'hA5, p[7:0], {5'b0, p[10:8]}, a[7:0], a[15:8],
               c[7:0], c[15:8], c[23:16], c[31:24]};
    endtask

    task automatic chk_frame(input string tag);
        check({tag, "_len"}, 32'(q.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_w%0d", tag, i),
                  (i < q.size()) ? 32'(q[i]) : 32'hDEAD, 32'(ew[i]));
    endtask

    task automatic fire(input logic [10:0] p, input logic [15:0] a);
        opcode = 5'd3;
        @(posedge clk); #1;
        opcode  = 5'd0;
        pc      = p;
        acc     = a;
        exp_cnt = cyc;
    endtask

    task automatic wait_fd(input string tag, input int bound);
        int s = fd_cnt;
        int n = 0;
        while (fd_cnt == s && n < bound) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(fd_cnt - s), 32'd1);
    endtask

    task automatic wait_q(input int n, input int bound);
        int i = 0;
        while (q.size() < n && i < bound) begin
            @(posedge clk);
            i++;
        end
        check("wait_words", 32'(q.size() >= n), 32'd1);
    endtask

    initial begin
        int s;
        logic [7:0] e2[6];
        rst      = 1'b1;
        opcode   = 5'd3;
        pc       = '0;
        acc      = '0;
        auto_ack = 1'b1;
        man_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data",  32'(data),     32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_fdone", 32'(fdone),    32'd0);
        rst = 1'b0;

        // Frame 1: trigger edge sees counter == 100
        repeat (100) @(posedge clk);
        #1;
        opcode = 5'd0;
        pc     = 11'h5A3;
        acc    = 16'hBEEF;
        @(posedge clk); #1;
        check("f1_start", 32'(tx_start), 32'd1);
        check("f1_hdr",   32'(data),     32'hA5);
        check("f1_busy",  32'(busy),     32'd1);
        wait_fd("f1_done", 300);
        repeat (5) @(posedge clk);
        #1;
        check("f1_idle", 32'(busy), 32'd0);
        ew = '{8'hA5, 8'hA3, 8'h05, 8'hEF, 8'hBE,
               8'h64, 8'h00, 8'h00, 8'h00};
        chk_frame("f1");
        e2 = '{8'hA5, 8'hA3, 8'h05, 8'hEF, 8'hBE, 8'h0F};
        check("c4_len", 32'(q2.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("c4_w%0d", i),
                  (i < q2.size()) ? 32'(q2[i]) : 32'hDEAD, 32'(e2[i]));

        // Halt level held: no retrigger
        q.delete();
        s = fd_cnt;
        repeat (500) @(posedge clk);
        check("hold_starts", 32'(q.size()), 32'd0);
        check("hold_fdone",  32'(fd_cnt - s), 32'd0);

        // Mid-frame halt toggle and input changes are ignored
        q.delete();
        fire(11'h123, 16'h4567);
        repeat (15) @(posedge clk);
        #1 opcode = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        opcode = 5'd0;
        pc     = 11'h7FF;
        acc    = 16'h0000;
        wait_fd("f38_done", 300);
        repeat (5) @(posedge clk);
        mk(11'h123, 16'h4567, exp_cnt);
        chk_frame("f38");

        // Done held high: stall after first word until a fresh edge
        q.delete();
        auto_ack = 1'b0;
        man_done = 1'b1;
        fire(11'h0F0, 16'h1234);
        repeat (40) @(posedge clk);
        #1;
        check("stall_one", 32'(q.size()), 32'd1);
        man_done = 1'b0;
        @(posedge clk); #1;
        man_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("resume_two", 32'(q.size()), 32'd2);
        check("resume_word",
              (q.size() > 1) ? 32'(q[1]) : 32'hDEAD, 32'hF0);
        rst      = 1'b1;
        opcode   = 5'd3;
        man_done = 1'b0;
        auto_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset after word 4 aborts the frame
        q.delete();
        fire(11'h2C4, 16'h0ACE);
        wait_q(4, 200);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_start", 32'(tx_start), 32'd0);
        check("abort_data",  32'(data),     32'd0);
        check("abort_busy",  32'(busy),     32'd0);
        check("abort_fdone", 32'(fdone),    32'd0);
        opcode = 5'd3;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        repeat (50) @(posedge clk);
        #1;
        check("abort_quiet", 32'(q.size()), 32'd0);
        check("abort_idle",  32'(busy),     32'd0);

        // Halt already present at release counts as a trigger
        @(negedge clk);
        rst    = 1'b1;
        opcode = 5'd0;
        pc     = 11'h7FF;
        acc    = 16'h8001;
        @(negedge clk);
        q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_busy", 32'(busy), 32'd1);
        wait_fd("rel_done", 300);
        repeat (5) @(posedge clk);
        mk(11'h7FF, 16'h8001, 32'd0);
        chk_frame("rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
